// File: rtl/lsu_pkg.sv
// Shared constants for the load/store sequencer: FSM state codes, funct3 encodings
// and byte-enable width, plus the funct3 legality helper used at access start.
package lsu_pkg;

  localparam int BE_W = 4;

  typedef logic [2:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE     = 3'd0;
  localparam lsu_state_t ST_REQ      = 3'd1;
  localparam lsu_state_t ST_WAIT_RSP = 3'd2;
  localparam lsu_state_t ST_DONE     = 3'd3;
  localparam lsu_state_t ST_ERR      = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and load lane
// extraction with sign/zero extension, all driven from the latched access.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rsp_word,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0]   byte_shift;
  logic [XLEN-1:0]   half_shift;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    byte_shift = rsp_word >> {addr_lo, 3'b000};
    half_shift = rsp_word >> {addr_lo[1], 4'b0000};
    lane_b     = byte_shift[7:0];
    lane_h     = half_shift[15:0];

    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    load_data = rsp_word;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_H:    load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane_b};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// RV32I load/store sequencer: one decoded access -> one valid/ready bus transaction.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses to ERR.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [BE_W-1:0] dmem_req_be,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            start;
  logic            legal;
  logic            misalign;
  logic [BE_W-1:0] be_a;
  logic [XLEN-1:0] wdata_a;
  logic [XLEN-1:0] load_a;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign start = (state_q == ST_IDLE) && (mem_read || mem_write);
  assign legal = !(mem_read && mem_write) && f3_legal(mem_write, funct3) && !misalign;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rsp_word  (dmem_rsp_rdata),
    .be        (be_a),
    .wdata_rep (wdata_a),
    .load_data (load_a)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          f3_d    = funct3;
          we_d    = mem_write;
          state_d = legal ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) state_d = we_q ? ST_DONE : ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          rdata_d = load_a;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Async reset also clears data so every output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall          = start || (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);
  assign done           = (state_q == ST_DONE);
  assign err            = (state_q == ST_ERR);
  assign rdata          = rdata_q;
  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_req_we    = dmem_req_valid && we_q;
  assign dmem_req_addr  = dmem_req_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_req_be    = dmem_req_valid ? be_a : '0;
  assign dmem_req_wdata = dmem_req_valid ? wdata_a : '0;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: expected transactions are queued per access
// and checked when the DUT issues its request and when it retires.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        dmem_req_valid, dmem_req_we;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_err;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          ret_cyc;
  } exp_t;

  exp_t sb_q[$];

  logic [63:0] obs_stall;
  int          obs_done_cnt;
  logic        obs_stable;
  logic        obs_valid_seen;

  lsu_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .done           (done),
    .rdata          (rdata),
    .err            (err),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_be    (dmem_req_be),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic is_err, input logic we, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic chk, input logic [31:0] rd, input int cyc);
    exp_t e;
    e.is_err = is_err; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
    e.chk_rdata = chk; e.rdata = rd; e.ret_cyc = cyc;
    return e;
  endfunction

  // Drives one access from the IDLE cycle after a posedge, plays the bus slave and
  // checks the DUT against the head of the scoreboard; returns just after retire.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input int rdy_dly, input int rsp_dly, input logic [31:0] word);
    exp_t e;
    int req_cnt = 0;
    int wait_cnt = 0;
    bit accepted = 0;
    bit fin = 0;
    logic [68:0] first_req = '0;
    if (sb_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s scoreboard empty got 0 entries want 1", tag);
      return;
    end
    e = sb_q.pop_front();
    obs_stall = '0; obs_done_cnt = 0; obs_stable = 1'b1; obs_valid_seen = 1'b0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 60 && !fin; c++) begin
      if (c > 0) begin
        mem_read = 1'b0; mem_write = 1'b0;
        addr = 32'h5555_5555; wdata = 32'h3333_3333; funct3 = 3'b111;
      end
      dmem_req_ready = dmem_req_valid && (req_cnt >= rdy_dly);
      if (accepted) begin
        dmem_rsp_valid = (wait_cnt == rsp_dly);
        dmem_rsp_rdata = dmem_rsp_valid ? word : 32'h0;
        wait_cnt++;
      end else begin
        dmem_rsp_valid = dmem_req_valid;
        dmem_rsp_rdata = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      obs_stall[c[5:0]] = stall;
      if (dmem_req_valid) begin
        if (!obs_valid_seen) begin
          first_req = {dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata};
          checks++;
          if (e.is_err) begin
            errors++;
            $display("FAIL %s_no_req got valid=1 want valid=0", tag);
          end else if ({dmem_req_we, dmem_req_addr, dmem_req_be} !== {e.we, e.addr, e.be}) begin
            errors++;
            $display("FAIL %s_req got we=%b addr=%h be=%b want we=%b addr=%h be=%b", tag,
                     dmem_req_we, dmem_req_addr, dmem_req_be, e.we, e.addr, e.be);
          end
          if (e.we) begin
            checks++;
            if (dmem_req_wdata !== e.wdata) begin
              errors++;
              $display("FAIL %s_wdata got %h want %h", tag, dmem_req_wdata, e.wdata);
            end
          end
        end else if ({dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata} !== first_req) begin
          obs_stable = 1'b0;
        end
        obs_valid_seen = 1'b1;
        req_cnt++;
        if (dmem_req_ready) accepted = 1;
      end
      if (done || err) begin
        if (done) obs_done_cnt++;
        fin = 1;
        checks++;
        if (err !== e.is_err || done === e.is_err) begin
          errors++;
          $display("FAIL %s_kind got done=%b err=%b want err=%b", tag, done, err, e.is_err);
        end
        checks++;
        if (c != e.ret_cyc) begin
          errors++;
          $display("FAIL %s_latency got cycle %0d want cycle %0d", tag, c, e.ret_cyc);
        end
        if (e.chk_rdata) begin
          checks++;
          if (rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s_rdata got %h want %h", tag, rdata, e.rdata);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    if (!fin) begin
      errors++; checks++;
      $display("FAIL %s_timeout got no retire want retire within 60 cycles", tag);
    end
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, done, err, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be,
         dmem_req_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b done=%b err=%b valid=%b rdata=%h want all 0",
               stall, done, err, dmem_req_valid, rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    sb_q.push_back(mk(0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 2));
    run_access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    checks++;
    if (obs_stall[2:0] !== 3'b011) begin
      errors++;
      $display("FAIL sw_stall got %b want 011", obs_stall[2:0]);
    end
    sb_q.push_back(mk(0, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 0, 0, 2));
    run_access("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0);
    sb_q.push_back(mk(0, 1, 32'h40, 4'b1100, 32'hBEEFBEEF, 0, 0, 2));
    run_access("sh", 0, 1, 3'b001, 32'h42, 32'h1234BEEF, 0, 0, 0);
  endtask

  task automatic test_load();
    sb_q.push_back(mk(0, 0, 32'h100, 4'b0100, 0, 1, 32'hFFFFFFC3, 3));
    run_access("lb", 1, 0, 3'b000, 32'h102, 0, 0, 0, 32'h12C3_5678);
    sb_q.push_back(mk(0, 0, 32'h100, 4'b0100, 0, 1, 32'h000000C3, 3));
    run_access("lbu", 1, 0, 3'b100, 32'h102, 0, 0, 0, 32'h12C3_5678);
    sb_q.push_back(mk(0, 0, 32'h80, 4'b0011, 0, 1, 32'hFFFF9ABC, 3));
    run_access("lh", 1, 0, 3'b001, 32'h80, 0, 0, 0, 32'h0000_9ABC);
    checks++;
    if (obs_stall[3:0] !== 4'b0111) begin
      errors++;
      $display("FAIL lh_stall got %b want 0111", obs_stall[3:0]);
    end
  endtask

  task automatic test_stall_ready();
    sb_q.push_back(mk(0, 0, 32'h200, 4'b1100, 0, 1, 32'h00008001, 8));
    run_access("lhu_wait", 1, 0, 3'b101, 32'h202, 0, 3, 2, 32'h8001_0000);
    checks++;
    if (obs_stable !== 1'b1) begin
      errors++;
      $display("FAIL lhu_wait_stable got %b want 1", obs_stable);
    end
    @(negedge clk);
    checks++;
    if (obs_done_cnt + int'(done) != 1) begin
      errors++;
      $display("FAIL lhu_wait_done_once got %0d want 1", obs_done_cnt + int'(done));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    sb_q.push_back(mk(1, 0, 0, 0, 0, 1, 32'h00008001, 1));
    run_access("rd_and_wr", 1, 1, 3'b010, 32'h100, 32'h1, 0, 0, 0);
    checks++;
    if (obs_stall[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL rd_and_wr_stall got %b want 01", obs_stall[1:0]);
    end
    sb_q.push_back(mk(1, 0, 0, 0, 0, 1, 32'h00008001, 1));
    run_access("load_f3_011", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0);
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    run_access("store_f3_100", 0, 1, 3'b100, 32'h100, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    run_access("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 32'hCAFEF00D);
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    run_access("lh_mis", 1, 0, 3'b001, 32'h101, 0, 0, 0, 32'h1234_8765);
`else
    sb_q.push_back(mk(0, 0, 32'h100, 4'b1111, 0, 1, 32'hCAFEF00D, 3));
    run_access("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 32'hCAFEF00D);
    sb_q.push_back(mk(0, 0, 32'h100, 4'b0011, 0, 1, 32'hFFFF8765, 3));
    run_access("lh_mis", 1, 0, 3'b001, 32'h101, 0, 0, 0, 32'h1234_8765);
`endif
  endtask

  task automatic test_back_to_back();
    sb_q.push_back(mk(0, 1, 32'h10, 4'b0010, 32'h7E7E7E7E, 0, 0, 2));
    sb_q.push_back(mk(0, 1, 32'h20, 4'b1111, 32'h01234567, 0, 0, 2));
    sb_q.push_back(mk(0, 0, 32'h30, 4'b1000, 0, 1, 32'h000000F0, 3));
    run_access("b2b_sb", 0, 1, 3'b000, 32'h11, 32'hFFFFFF7E, 0, 0, 0);
    run_access("b2b_sw", 0, 1, 3'b010, 32'h20, 32'h01234567, 0, 0, 0);
    run_access("b2b_lbu", 1, 0, 3'b100, 32'h33, 0, 0, 0, 32'hF000_0000);
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    mem_read = 1'b0; dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    checks++;
    if ({stall, dmem_req_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mid_wait_state got stall=%b valid=%b want stall=1 valid=0", stall, dmem_req_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, dmem_req_valid, done, rdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset got stall=%b valid=%b done=%b rdata=%h want all 0",
               stall, dmem_req_valid, done, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      dmem_rsp_valid = 1'b0;
    end
    checks++;
    if (dcnt != 0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_done got done_count=%0d stall=%b want 0 and 0", dcnt, stall);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_stall_ready();
    test_illegal();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer for the RV32I core. It sits between the instruction decoder's `MemRead`/`MemWrite`/`funct3` outputs and the data-memory port. It converts one LB/LH/LW/LBU/LHU/SB/SH/SW into a valid/ready bus transaction with byte enables, then steers and extends load data. It stalls the core until the access retires.

## Interface
- `XLEN`, 32, data and address width (only 32 supported)
- `clk`  in  1  core clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_read`  in  1  decoder MemRead for the current instruction
- `mem_write`  in  1  decoder MemWrite for the current instruction
- `funct3`  in  3  access size/sign field of the instruction
- `addr`  in  XLEN  effective address (ALU result)
- `wdata`  in  XLEN  store data (rs2)
- `stall`  out  1  hold PC/pipeline while high
- `done`  out  1  one-cycle pulse when the access retires
- `rdata`  out  XLEN  extended load result, valid with `done`
- `err`  out  1  one-cycle pulse, illegal or misaligned access (no bus traffic)
- `dmem_req_valid`  out  1  bus request valid
- `dmem_req_ready`  in  1  bus accepts request
- `dmem_req_we`  out  1  1 = write
- `dmem_req_addr`  out  XLEN  word-aligned address (`addr[31:2],2'b00`)
- `dmem_req_be`  out  4  byte enables
- `dmem_req_wdata`  out  XLEN  lane-replicated store data
- `dmem_rsp_valid`  in  1  read data valid
- `dmem_rsp_rdata`  in  XLEN  read word

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE, ERR.
- Start condition: IDLE and (`mem_read` or `mem_write`). On start, latch `addr`, `wdata`, `funct3`, and the direction.
- Legality check at start:
  - both `mem_read` and `mem_write` high → illegal;
  - load `funct3` must be in {000, 001, 010, 100, 101};
  - store `funct3` must be in {000, 001, 010}.
  - An illegal access goes to ERR.
- REQ: `dmem_req_valid`=1. Request fields come from latched values and are stable until `dmem_req_ready`.
  - On ready with store → DONE.
  - On ready with load → WAIT_RSP.
- WAIT_RSP: on `dmem_rsp_valid`, capture the extended load data → DONE.
  - `dmem_rsp_valid` in any other state is ignored.
- DONE: `done`=1 → IDLE.
- ERR: `err`=1, `rdata` held → IDLE.
- Byte enables:
  - byte → `4'b0001 << addr[1:0]`
  - half → `4'b0011 << {addr[1],1'b0}`
  - word → `4'b1111`
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load extraction: select the lane by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - `rdata` holds its last value outside DONE.
- `stall` = start condition (combinational) or state ∈ {REQ, WAIT_RSP}.
  - `stall` is 0 in DONE and ERR, so the core advances in the retire cycle.
  - Decoder inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE; all outputs 0, including `rdata` = 0.
- Store with `dmem_req_ready` high in its first REQ cycle:
  - start at cycle 0, REQ at cycle 1, `done` at cycle 2.
- Load with read data in the cycle after acceptance:
  - REQ at cycle 1, WAIT_RSP at cycle 2 (rsp), `done` at cycle 3.
- Minimum back-to-back: a new start is accepted in the cycle after DONE.
- Ready held low keeps the block in REQ indefinitely; there is no timeout.
- Reset asserted mid-operation: immediately IDLE, `dmem_req_valid` drops asynchronously, and no `done` is produced.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - the start check also flags halfword with `addr[0]`=1 and word with `addr[1:0]`≠0;
  - such accesses go to ERR with no bus request.
- Not defined:
  - misaligned addresses are not checked;
  - lane selection and byte enables use the rules above unchanged (half at offset 1 uses lanes 0–1, word ignores `addr[1:0]`);
  - `err` fires only for illegal encodings.

## Structure
- Package `lsu_pkg`:
  - state enum;
  - `funct3` constants (`F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101);
  - byte-enable width constant.
- Sub-module `lsu_align`, purely combinational: byte-enable generation, store replication and load extraction/extension. The FSM instantiates it once.

## Test plan
- SW: `addr`=0x100, `wdata`=0xDEADBEEF, ready immediate → `dmem_req_be`=1111, `dmem_req_wdata`=0xDEADBEEF, `done` at cycle 2, `stall` high cycles 0–1.
- SB: `addr`=0x103, `wdata`=0x000000A5 → `dmem_req_addr`=0x100, `be`=1000, `wdata`=0xA5A5A5A5.
- LB: `addr`=0x102, response 0x12C3_5678 → `rdata`=0xFFFFFFC3. Same access as LBU → `rdata`=0x000000C3.
- LHU: `addr`=0x202, ready low 3 cycles, response 2 cycles later, word 0x8001_0000 → request fields stable during stall, `rdata`=0x00008001, `done` once.
- `mem_read`=`mem_write`=1, or load `funct3`=011 → `err` pulse at cycle 1, no `dmem_req_valid`. With the macro defined, LW `addr`=0x102 → `err`; without it → normal access with `be`=1111.
- `rst_n` low while in WAIT_RSP → state IDLE, `stall`=0, `dmem_req_valid`=0, no `done` after release.
